// File: rtl/latch_debounce_counter.sv
// Brings an asynchronous latch output into the clk domain, debounces it, and emits
// a clean level, single-cycle rise/fall pulses and a saturating count of accepted rises.
module latch_debounce_counter #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             clr_cnt,
    output logic             level,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             cnt_sat
);
    localparam int                STAB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {LOW, GO_HIGH, HIGH, GO_LOW} state_t;

    state_t              state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [STAB_W-1:0]   stab_q, stab_d;
    logic                level_q, level_d;
    logic                rise_q, rise_d;
    logic                fall_q, fall_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sat_q, sat_d;
    logic                s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        stab_d  = stab_q;
        case (state_q)
            LOW: begin
                if (s) begin
                    state_d = GO_HIGH;
                    stab_d  = STAB_ONE;
                end
            end
            GO_HIGH: begin
                if (!s) begin
                    state_d = LOW;
                    stab_d  = '0;
                end else if (stab_q == STAB_LAST) begin
                    state_d = HIGH;
                    stab_d  = '0;
                end else begin
                    stab_d = stab_q + STAB_ONE;
                end
            end
            HIGH: begin
                if (!s) begin
                    state_d = GO_LOW;
                    stab_d  = STAB_ONE;
                end
            end
            GO_LOW: begin
                if (s) begin
                    state_d = HIGH;
                    stab_d  = '0;
                end else if (stab_q == STAB_LAST) begin
                    state_d = LOW;
                    stab_d  = '0;
                end else begin
                    stab_d = stab_q + STAB_ONE;
                end
            end
            default: begin
                state_d = LOW;
                stab_d  = '0;
            end
        endcase

        // Outputs are registered from the next state so they line up with the state change.
        level_d = (state_d == HIGH) || (state_d == GO_LOW);
        rise_d  = (state_q == GO_HIGH) && (state_d == HIGH);
        fall_d  = (state_q == GO_LOW) && (state_d == LOW);

        cnt_d = clr_cnt ? '0 : cnt_q;
        if (rise_d) begin
            cnt_d = sat_inc(cnt_d);
        end
        sat_d = (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            state_q <= LOW;
            stab_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
            state_q <= state_d;
            stab_q  <= stab_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    assign level      = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign edge_cnt   = cnt_q;
    assign cnt_sat    = sat_q;

endmodule

// File: doc/latch_debounce_counter.md
Name: latch_debounce_counter

Overview:
- Downstream consumer of the level-sensitive D latch output (q).
- Synchronises the latch output into the clk domain, debounces it and emits a clean level plus one-cycle rise/fall pulses.
- Counts debounced rising edges in a saturating counter.
- Feeds control logic that needs glitch-free single-cycle events from latch-held data.

Parameters:
SYNC_STAGES, 2, number of flops in the synchroniser chain (>=2)
DEBOUNCE_CYCLES, 4, consecutive synchronised samples required to accept a level change (>=2)
CNT_W, 8, width of the rising-edge counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset; asynchronous, active-low (rst=0 resets)
din  input  1  asynchronous input, driven by the latch q
clr_cnt  input  1  synchronous clear of edge_cnt, sampled on clk rising edge
level  output  1  debounced, synchronised version of din
rise_pulse  output  1  one-cycle pulse on accepted 0->1 transition
fall_pulse  output  1  one-cycle pulse on accepted 1->0 transition
edge_cnt  output  CNT_W  count of accepted rising transitions, saturating
cnt_sat  output  1  high while edge_cnt == 2^CNT_W-1

Behaviour:
- Reset (rst=0): asynchronous, no clock needed.
  - Sync chain, debounce counter, state, level, rise_pulse, fall_pulse, edge_cnt and cnt_sat all go to 0.
  - FSM state goes to LOW.
- Synchroniser: din shifts through SYNC_STAGES flops. s = last stage. No logic on din before the first flop.
- Debounce counter: stab_cnt, width clog2(DEBOUNCE_CYCLES+1).
- FSM states: LOW, GO_HIGH, HIGH, GO_LOW.
  - LOW: s=1 -> GO_HIGH, stab_cnt=1. Otherwise stay.
  - GO_HIGH: s=0 -> LOW, stab_cnt=0. s=1 and stab_cnt==DEBOUNCE_CYCLES-1 -> HIGH. Otherwise stab_cnt+1.
  - HIGH / GO_LOW: mirror of LOW / GO_HIGH with s inverted; GO_LOW completes to LOW.
- level: registered; 1 in HIGH and GO_LOW, 0 in LOW and GO_HIGH.
- Latency: level changes on the (SYNC_STAGES+DEBOUNCE_CYCLES)th rising clk edge after din changes, provided din holds. Defaults give 6 edges.
- Pulses:
  - rise_pulse is 1 for exactly the cycle after the GO_HIGH->HIGH edge, coincident with level first reading 1.
  - fall_pulse is the same for GO_LOW->LOW.
  - Never both high. Never high in consecutive cycles.
- Glitch rejection: any din excursion shorter than DEBOUNCE_CYCLES synchronised samples gives no level change and no pulse.
- Counter:
  - edge_cnt increments on the same edge that sets rise_pulse.
  - Holds at 2^CNT_W-1; cnt_sat is a registered compare with edge_cnt.
  - clr_cnt=1 with no accepted rise: edge_cnt=0 next edge.
  - clr_cnt=1 on the same edge as an accepted rise: edge_cnt=1 (clear, then count).
  - Falling transitions never change edge_cnt.
- Reset mid-operation: in-progress debounce is discarded.
  - If din=1 at release, the block runs the full sync+debounce path from LOW.
  - It then issues rise_pulse and edge_cnt becomes 1.
- Arithmetic: edge_cnt is unsigned; no wrap.

Test Plan:
- Async reset: drive rst=0 between clk edges with level=1, edge_cnt=5 -> all outputs 0 immediately, before the next clk edge.
- Clean rise (defaults): din 0->1 held 20 cycles -> level=1 at 6th edge, rise_pulse high exactly 1 cycle, edge_cnt=1, fall_pulse stays 0.
- Glitch: din high for 3 cycles, then low -> level, rise_pulse, fall_pulse stay 0, edge_cnt stays 0. Then din high for 5 cycles, then low -> level rises, edge_cnt=1, followed by a fall after 6 more edges.
- Clean fall: from HIGH, din 1->0 held 10 cycles -> level=0 at 6th edge, fall_pulse for 1 cycle, edge_cnt unchanged.
- Saturation and clear: CNT_W=3, 9 clean pulses (each 8 cycles high, 8 low) -> edge_cnt=7, cnt_sat=1 after the 7th. Then clr_cnt asserted on the edge of a 10th accepted rise -> edge_cnt=1, cnt_sat=0.
- Reset mid-debounce: din high, assert rst in GO_HIGH (stab_cnt=2) -> all outputs 0. Release with din held high -> level rises 6 edges after release, edge_cnt=1.
